uart_command_serializer: RTL and testbench

//   Downstream stage of the UART command accumulator. Takes an accumulated command buffer (up to
//   128 bytes, byte 0 in bits [7:0]) and its byte count, then streams the bytes to a UART TX

---
 rtl/uart_cmd_pkg.sv | 26 ++
 rtl/uart_tx_timeout.sv | 29 ++
 rtl/uart_command_serializer.sv | 181 ++++++++++++++++++
 tb/tb_uart_command_serializer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command accumulator and serializer:
// FSM encoding, link terminator bytes and command buffer geometry.
package uart_cmd_pkg;

  localparam int CMD_MAX_BYTES = 128;
  localparam int CMD_BUS_W     = 1024;

  localparam logic [7:0] CMD_TERM_CR = 8'h0D;
  localparam logic [7:0] CMD_TERM_HI = 8'hBE;
  localparam logic [7:0] CMD_TERM_LO = 8'hEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_CSUM,
    ST_TERM1,
    ST_TERM2,
    ST_FINISH
  } ser_state_e;

  // BLE links end with a single CR; host links start a two-byte 0xBEEF trailer.
  function automatic logic [7:0] term_first(input logic ble_side);
    return ble_side ? CMD_TERM_CR : CMD_TERM_HI;
  endfunction

endpackage

// File: rtl/uart_tx_timeout.sv
// Stall watchdog for a valid/ready TX link: counts enabled cycles since the last
// clear and flags the cycle in which the TIMEOUT-th stalled cycle occurs.
module uart_tx_timeout #(
  parameter int TIMEOUT = 2000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && !clear && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/uart_command_serializer.sv
// Streams a latched command buffer to a UART TX over valid/ready and appends the
// link terminator. Optional XOR checksum byte: define UART_CMD_SER_CHECKSUM_EN.
module uart_command_serializer
  import uart_cmd_pkg::*;
#(
  parameter int MAX_BYTES = CMD_MAX_BYTES,
  parameter int TIMEOUT   = 2000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CMD_BUS_W-1:0] cmd_data,
  input  logic [7:0]           cmd_size,
  input  logic                 cmd_valid,
  input  logic                 ble_side,
  input  logic                 abort,
  output logic                 cmd_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 done,
  output logic                 error
);

  ser_state_e           state, state_d;
  logic [6:0]           idx, idx_d, idx_n;
  logic [7:0]           tx_data_d;
  logic                 tx_valid_d, cmd_ready_d, done_d, error_d;
  logic [CMD_BUS_W-1:0] cmd_q;
  logic [7:0]           size_q;
  logic                 side_q;
  logic                 hs, accept, bad_size, last, expired;
`ifdef UART_CMD_SER_CHECKSUM_EN
  logic [7:0]           csum, csum_d;
`endif

  assign hs       = tx_valid && tx_ready;
  assign accept   = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign bad_size = (cmd_size == 8'd0) || (int'(cmd_size) > MAX_BYTES);
  assign last     = ({1'b0, idx} == (size_q - 8'd1));
  assign idx_n    = idx + 7'd1;

  uart_tx_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (hs || !tx_valid),
    .enable  (tx_valid && !tx_ready),
    .expired (expired)
  );

  // Command latch: only the copies taken at acceptance drive the frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q  <= cmd_data;
      size_q <= cmd_size;
      side_q <= ble_side;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef UART_CMD_SER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      cmd_ready <= cmd_ready_d;
      done      <= done_d;
      error     <= error_d;
`ifdef UART_CMD_SER_CHECKSUM_EN
      csum      <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    cmd_ready_d = cmd_ready;
    done_d      = 1'b0;
    error_d     = 1'b0;
`ifdef UART_CMD_SER_CHECKSUM_EN
    csum_d      = csum;
`endif
    case (state)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          if (bad_size) begin
            error_d = 1'b1;
          end else begin
            state_d    = ST_SEND;
            idx_d      = '0;
            tx_valid_d = 1'b1;
            tx_data_d  = cmd_data[7:0];
`ifdef UART_CMD_SER_CHECKSUM_EN
            csum_d     = '0;
`endif
          end
        end
      end
      ST_SEND: begin
        if (hs) begin
`ifdef UART_CMD_SER_CHECKSUM_EN
          csum_d = csum ^ tx_data;
`endif
          if (last) begin
`ifdef UART_CMD_SER_CHECKSUM_EN
            state_d   = ST_CSUM;
            tx_data_d = csum ^ tx_data;
`else
            state_d   = ST_TERM1;
            tx_data_d = term_first(side_q);
`endif
          end else begin
            idx_d     = idx_n;
            tx_data_d = cmd_q[8*idx_n +: 8];
          end
        end
      end
`ifdef UART_CMD_SER_CHECKSUM_EN
      ST_CSUM: begin
        if (hs) begin
          state_d   = ST_TERM1;
          tx_data_d = term_first(side_q);
        end
      end
`endif
      ST_TERM1: begin
        if (hs) begin
          if (side_q) begin
            state_d    = ST_FINISH;
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            state_d   = ST_TERM2;
            tx_data_d = CMD_TERM_LO;
          end
        end
      end
      ST_TERM2: begin
        if (hs) begin
          state_d    = ST_FINISH;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        tx_valid_d  = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase

    // Abort and stall timeout both drop the frame without completing it.
    if ((state != ST_IDLE) && (abort || expired)) begin
      state_d     = ST_IDLE;
      tx_valid_d  = 1'b0;
      cmd_ready_d = 1'b1;
      done_d      = 1'b0;
      error_d     = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_command_serializer.sv
// Scoreboard bench for uart_command_serializer: expected TX bytes and done/error
// events are queued by the stimulus and consumed by a negedge monitor.
module tb_uart_command_serializer;

  localparam int TMO = 2000;
  localparam int K_BYTE = 0, K_DONE = 1, K_ERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1023:0] cmd_data = '0;
  logic [7:0]    cmd_size = '0;
  logic          cmd_valid = 1'b0;
  logic          ble_side = 1'b0;
  logic          abort = 1'b0;
  logic          cmd_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          done;
  logic          error;

  int  tests = 0;
  int  fails = 0;
  ev_t exp_q[$];

  uart_command_serializer #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_data  (cmd_data),
    .cmd_size  (cmd_size),
    .cmd_valid (cmd_valid),
    .ble_side  (ble_side),
    .abort     (abort),
    .cmd_ready (cmd_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input logic [7:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk($sformatf("unexpected_event_kind%0d", kind), {24'd0, val}, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == K_BYTE) chk("tx_byte", {24'd0, val}, {24'd0, e.val});
    end
  endtask

  always @(negedge clk) begin
    if (tx_valid === 1'b1 && tx_ready === 1'b1) pop_chk(K_BYTE, tx_data);
    if (done === 1'b1) pop_chk(K_DONE, 8'h00);
    if (error === 1'b1) pop_chk(K_ERR, 8'h00);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1023:0] d, input logic [7:0] sz, input logic side);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_before_send", cmd_ready, 1);
    cmd_data  = d;
    cmd_size  = sz;
    ble_side  = side;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    // Scramble inputs mid-frame; only latched copies may matter.
    cmd_data  = '1;
    cmd_size  = 8'hFF;
    ble_side  = ~side;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] t1 [4];
    logic [7:0] held;
    logic       early_err;
    t1 = '{8'h41, 8'h42, 8'h43, 8'h0D};

    // Reset state
    reset = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b1;
    tick();

    // 1) BLE frame, size 3, tx_ready held high
    tx_ready = 1'b1;
    foreach (t1[i]) push(K_BYTE, t1[i]);
    push(K_DONE, 8'h00);
    send(1024'(24'h434241), 8'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_valid%0d", i), tx_valid, 1);
      chk($sformatf("t1_data%0d", i), tx_data, t1[i]);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_valid_finish", tx_valid, 0);
    tick();
    chk("t1_cmd_ready", cmd_ready, 1);
    chk("t1_done_clear", done, 0);
    drain("t1_drain", 20);

    // 2) host frame, size 2, tx_ready toggling
    push(K_BYTE, 8'h41); push(K_BYTE, 8'h42);
    push(K_BYTE, 8'hBE); push(K_BYTE, 8'hEF);
    push(K_DONE, 8'h00);
    send(1024'(16'h4241), 8'd2, 1'b0);
    held = 8'h00;
    for (int k = 0; k < 7; k++) begin
      tx_ready = (k % 2 == 0);
      if (k % 2 == 1) held = tx_data;
      else if (k > 0) begin
        chk($sformatf("t2_hold%0d", k), tx_data, held);
        chk($sformatf("t2_hold_valid%0d", k), tx_valid, 1);
      end
      tick();
    end
    tx_ready = 1'b1;
    chk("t2_done", done, 1);
    drain("t2_drain", 20);

    // 3) illegal sizes 0 and 129
    push(K_ERR, 8'h00);
    send(1024'(8'h11), 8'd0, 1'b1);
    chk("t3a_error", error, 1);
    chk("t3a_tx_valid", tx_valid, 0);
    chk("t3a_cmd_ready_low", cmd_ready, 0);
    tick();
    chk("t3a_cmd_ready", cmd_ready, 1);
    chk("t3a_tx_valid2", tx_valid, 0);
    push(K_ERR, 8'h00);
    send(1024'(8'h11), 8'd129, 1'b1);
    chk("t3b_error", error, 1);
    chk("t3b_tx_valid", tx_valid, 0);
    tick();
    chk("t3b_cmd_ready", cmd_ready, 1);
    chk("t3b_tx_valid2", tx_valid, 0);
    drain("t3_drain", 5);

    // 4) stall on byte 1 until timeout
    push(K_BYTE, 8'h41);
    push(K_ERR, 8'h00);
    send(1024'(24'h434241), 8'd3, 1'b1);
    tick();
    tx_ready = 1'b0;
    chk("t4_byte1", tx_data, 8'h42);
    early_err = 1'b0;
    for (int j = 1; j < TMO; j++) begin
      tick();
      if (error !== 1'b0 || tx_valid !== 1'b1) early_err = 1'b1;
    end
    chk("t4_no_early_error", early_err, 0);
    tick();
    chk("t4_error", error, 1);
    chk("t4_tx_valid", tx_valid, 0);
    tick();
    chk("t4_cmd_ready", cmd_ready, 1);
    chk("t4_no_done", done, 0);
    tx_ready = 1'b1;
    drain("t4_drain", 5);

    // 5) abort in TERM2, then reset mid-SEND, then a size-1 frame
    push(K_BYTE, 8'h41); push(K_BYTE, 8'h42); push(K_BYTE, 8'hBE);
    push(K_ERR, 8'h00);
    send(1024'(16'h4241), 8'd2, 1'b0);
    tick(); tick(); tick();
    tx_ready = 1'b0;
    abort    = 1'b1;
    chk("t5_term2_byte", tx_data, 8'hEF);
    tick();
    abort    = 1'b0;
    tx_ready = 1'b1;
    chk("t5_abort_error", error, 1);
    chk("t5_abort_valid", tx_valid, 0);
    chk("t5_abort_ready", cmd_ready, 1);
    drain("t5a_drain", 5);
    push(K_BYTE, 8'h41);
    send(1024'(24'h434241), 8'd3, 1'b1);
    tick();
    tx_ready = 1'b0;
    reset    = 1'b0;
    tick();
    chk("t5_rst_valid", tx_valid, 0);
    chk("t5_rst_data", tx_data, 0);
    chk("t5_rst_ready", cmd_ready, 1);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_error", error, 0);
    reset    = 1'b1;
    tx_ready = 1'b1;
    drain("t5b_drain", 5);
    push(K_BYTE, 8'h5A); push(K_BYTE, 8'h0D);
    push(K_DONE, 8'h00);
    send(1024'(8'h5A), 8'd1, 1'b1);
    drain("t5c_drain", 20);

    // 6) checksum-sensitive frame
    push(K_BYTE, 8'h01); push(K_BYTE, 8'h02); push(K_BYTE, 8'h04);
`ifdef UART_CMD_SER_CHECKSUM_EN
    push(K_BYTE, 8'h07);
`endif
    push(K_BYTE, 8'h0D);
    push(K_DONE, 8'h00);
    send(1024'(24'h040201), 8'd3, 1'b1);
    drain("t6_drain", 20);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
